// File: rtl/dhcen_gate_ctrl_if.sv
// Request/grant and clock-gate status bundle between requesters and dhcen_gate_ctrl.
// The master drives requests; the slave (the controller) drives grants and gate status.
interface dhcen_gate_ctrl_if #(
   parameter int unsigned N_REQ = 2
);
   logic [N_REQ-1:0] req;
   logic             force_on;
   logic [N_REQ-1:0] ack;
   logic             dhcen_ce;
   logic             clk_active;
   logic             busy;

   modport master (
      output req, force_on,
      input  ack, dhcen_ce, clk_active, busy
   );

   modport slave (
      input  req, force_on,
      output ack, dhcen_ce, clk_active, busy
   );
endinterface

// File: rtl/dhcen_gate_ctrl.sv
// DHCEN clock-gate sequencer: OFF -> WAKE -> ON -> DRAIN -> OFF, all outputs registered.
// Optional DHCEN_GATE_STATS_EN adds gate_off_count and on_cycles statistics outputs.
module dhcen_gate_ctrl #(
   parameter int unsigned N_REQ         = 2,
   parameter int unsigned WAKE_CYCLES   = 4,
   parameter int unsigned IDLE_CYCLES   = 8,
   parameter int unsigned GUARD_CYCLES  = 2,
   parameter bit          CE_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   dhcen_gate_ctrl_if.slave   bus
`ifdef DHCEN_GATE_STATS_EN
   ,
   output logic [15:0]        gate_off_count,
   output logic [31:0]        on_cycles
`endif
);

   localparam int unsigned MaxWI  = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
   localparam int unsigned MaxCyc = (MaxWI > GUARD_CYCLES) ? MaxWI : GUARD_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   localparam logic [CntW-1:0] WakeLast  = CntW'(WAKE_CYCLES - 1);
   localparam logic [CntW-1:0] IdleLast  = CntW'(IDLE_CYCLES - 1);
   localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);

   localparam logic CeOff = CE_ACTIVE_LOW;
   localparam logic CeOn  = ~CE_ACTIVE_LOW;

   typedef enum logic [1:0] {
      StOff,
      StWake,
      StOn,
      StDrain
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             ce_q, ce_d;
   logic             clk_active_q, clk_active_d;
   logic             busy_q, busy_d;
   logic             any_req;

   assign any_req = (|bus.req) | bus.force_on;

   // One counter serves wake, idle and guard timing; it is cleared on every state entry and
   // only advances while below its phase limit, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StOff: begin
            if (any_req) begin
               state_d = StWake;
               cnt_d   = '0;
            end
         end
         StWake: begin
            if (cnt_q >= WakeLast) begin
               state_d = StOn;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StOn: begin
            if (any_req) begin
               cnt_d = '0;
            end else if (cnt_q >= IdleLast) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            // Clock is still running, so a new request resumes ON without a wake delay.
            if (any_req) begin
               state_d = StOn;
               cnt_d   = '0;
            end else if (cnt_q >= GuardLast) begin
               state_d = StOff;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StOff;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ack_d        = (state_d == StOn) ? bus.req : '0;
      ce_d         = (state_d == StOff) ? CeOff : CeOn;
      clk_active_d = (state_d != StOff);
      busy_d       = (state_d == StWake) || (state_d == StDrain);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StOff;
         cnt_q        <= '0;
         ack_q        <= '0;
         ce_q         <= CeOff;
         clk_active_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         ce_q         <= ce_d;
         clk_active_q <= clk_active_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.dhcen_ce   = ce_q;
   assign bus.clk_active = clk_active_q;
   assign bus.busy       = busy_q;

`ifdef DHCEN_GATE_STATS_EN
   logic [15:0] gate_off_count_q, gate_off_count_d;
   logic [31:0] on_cycles_q, on_cycles_d;

   always_comb begin
      gate_off_count_d = gate_off_count_q;
      if ((state_q == StDrain) && (state_d == StOff) && (gate_off_count_q != 16'hFFFF)) begin
         gate_off_count_d = gate_off_count_q + 16'd1;
      end
      on_cycles_d = clk_active_q ? (on_cycles_q + 32'd1) : on_cycles_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gate_off_count_q <= '0;
         on_cycles_q      <= '0;
      end else begin
         gate_off_count_q <= gate_off_count_d;
         on_cycles_q      <= on_cycles_d;
      end
   end

   assign gate_off_count = gate_off_count_q;
   assign on_cycles      = on_cycles_q;
`endif

endmodule

// File: tb/tb_dhcen_gate_ctrl.sv
// Bench for dhcen_gate_ctrl: directed scenarios plus random requests against a
// behavioural model of the gate sequence (remaining-cycle counters, not FSM states).
module tb_dhcen_gate_ctrl;

   localparam int unsigned N_REQ         = 2;
   localparam int          WAKE_CYCLES   = 4;
   localparam int          IDLE_CYCLES   = 8;
   localparam int          GUARD_CYCLES  = 2;
   localparam bit          CE_ACTIVE_LOW = 1'b1;
   localparam logic        CE_EN         = ~CE_ACTIVE_LOW;
   localparam logic        CE_DIS        = CE_ACTIVE_LOW;

   logic clk;
   logic reset_n;

   dhcen_gate_ctrl_if #(.N_REQ(N_REQ)) bus ();

`ifdef DHCEN_GATE_STATS_EN
   logic [15:0] gate_off_count;
   logic [31:0] on_cycles;
`endif

   dhcen_gate_ctrl #(
      .N_REQ         (N_REQ),
      .WAKE_CYCLES   (WAKE_CYCLES),
      .IDLE_CYCLES   (IDLE_CYCLES),
      .GUARD_CYCLES  (GUARD_CYCLES),
      .CE_ACTIVE_LOW (CE_ACTIVE_LOW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus            (bus)
`ifdef DHCEN_GATE_STATS_EN
      ,
      .gate_off_count (gate_off_count),
      .on_cycles      (on_cycles)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   string phase = "reset";

   // Model: clock enabled flag plus cycles remaining in wake/guard and the idle run length.
   int         m_en;
   int         m_wake;
   int         m_drain;
   int         m_idle;
   logic [1:0] m_ack;
`ifdef DHCEN_GATE_STATS_EN
   int          m_offs;
   logic [31:0] m_on_cyc;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en    = 0;
      m_wake  = 0;
      m_drain = 0;
      m_idle  = 0;
      m_ack   = '0;
`ifdef DHCEN_GATE_STATS_EN
      m_offs   = 0;
      m_on_cyc = '0;
`endif
   endtask

   task automatic model_step(input logic [1:0] r, input logic f);
      bit any_r;
      any_r = (r != 2'b00) || f;
`ifdef DHCEN_GATE_STATS_EN
      if (m_en != 0) m_on_cyc = m_on_cyc + 32'd1;
`endif
      if (m_en == 0) begin
         m_ack = '0;
         if (any_r) begin
            m_en   = 1;
            m_wake = WAKE_CYCLES;
         end
      end else if (m_wake > 0) begin
         m_wake--;
         m_ack = '0;
         if (m_wake == 0) begin
            m_idle = 0;
            m_ack  = r;
         end
      end else if (m_drain > 0) begin
         if (any_r) begin
            m_drain = 0;
            m_idle  = 0;
            m_ack   = r;
         end else begin
            m_drain--;
            m_ack = '0;
            if (m_drain == 0) begin
               m_en = 0;
`ifdef DHCEN_GATE_STATS_EN
               if (m_offs < 16'hFFFF) m_offs++;
`endif
            end
         end
      end else begin
         m_ack = r;
         if (any_r) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == IDLE_CYCLES) m_drain = GUARD_CYCLES;
         end
      end
   endtask

   task automatic check_all();
      check("ack", 32'(bus.ack), 32'(m_ack));
      check("dhcen_ce", 32'(bus.dhcen_ce), (m_en != 0) ? 32'(CE_EN) : 32'(CE_DIS));
      check("clk_active", 32'(bus.clk_active), (m_en != 0) ? 32'd1 : 32'd0);
      check("busy", 32'(bus.busy), (m_wake > 0 || m_drain > 0) ? 32'd1 : 32'd0);
`ifdef DHCEN_GATE_STATS_EN
      check("gate_off_count", 32'(gate_off_count), 32'(m_offs));
      check("on_cycles", on_cycles, m_on_cyc);
`endif
   endtask

   // Advance one edge with the inputs currently driven, then compare 1 time unit later.
   task automatic cycle();
      logic [1:0] r;
      logic       f;
      r = bus.req;
      f = bus.force_on;
      @(posedge clk);
      model_step(r, f);
      #1;
      check_all();
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.req      = '0;
      bus.force_on = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // 1: idle after reset, nothing wakes.
      phase = "idle_after_reset";
      repeat (20) cycle();

      // 2: single request; explicit wake timing on top of the model.
      phase = "wake_timing";
      bus.req = 2'b01;
      for (int e = 1; e <= WAKE_CYCLES + 1; e++) begin
         cycle();
         check("busy_edge", 32'(bus.busy), (e <= WAKE_CYCLES) ? 32'd1 : 32'd0);
         check("ack_edge", 32'(bus.ack), (e == WAKE_CYCLES + 1) ? 32'd1 : 32'd0);
         check("ce_edge", 32'(bus.dhcen_ce), 32'(CE_EN));
      end
      repeat (5) cycle();

      // 3: drop request, idle drain, guard, gate off.
      phase = "idle_drain";
      bus.req = 2'b00;
      cycle();
      check("ack_fall", 32'(bus.ack), 32'd0);
      for (int i = 0; i < IDLE_CYCLES + GUARD_CYCLES + 2; i++) cycle();
      check("gated_off", 32'(bus.clk_active), 32'd0);

      // 4: request on the second DRAIN cycle resumes ON without wake.
      phase = "drain_resume";
      bus.req = 2'b01;
      for (int i = 0; i < WAKE_CYCLES + 2; i++) cycle();
      bus.req = 2'b00;
      for (int i = 0; i < 40 && m_drain == 0; i++) cycle();
      check("drain_reached", 32'(bus.busy), 32'd1);
      cycle();
      bus.req = 2'b10;
      cycle();
      check("resume_ack", 32'(bus.ack), 32'd2);
      check("resume_busy", 32'(bus.busy), 32'd0);
      check("resume_ce", 32'(bus.dhcen_ce), 32'(CE_EN));
      repeat (3) cycle();

      // 5: force_on holds the clock without acks, then drains once released.
      phase = "force_on";
      bus.req = 2'b00;
      bus.force_on = 1'b1;
      repeat (50) cycle();
      check("force_no_ack", 32'(bus.ack), 32'd0);
      check("force_active", 32'(bus.clk_active), 32'd1);
      bus.force_on = 1'b0;
      repeat (IDLE_CYCLES + GUARD_CYCLES + 3) cycle();
      check("force_released_off", 32'(bus.clk_active), 32'd0);

      // 6: asynchronous reset in ON with both acks high.
      phase = "async_reset";
      bus.req = 2'b11;
      repeat (WAKE_CYCLES + 3) cycle();
      check("pre_reset_ack", 32'(bus.ack), 32'd3);
      reset_n = 1'b0;
      #2;
      model_reset();
      check_all();
      check("rst_ce", 32'(bus.dhcen_ce), 32'(CE_DIS));
      #1;
      reset_n = 1'b1;
      bus.req = 2'b00;
      repeat (3) cycle();

`ifdef DHCEN_GATE_STATS_EN
      phase = "stats";
      for (int k = 0; k < 3; k++) begin
         bus.req = 2'b01;
         cycle();
         bus.req = 2'b00;
         for (int i = 0; i < 40 && m_en != 0; i++) cycle();
         check("stats_off", 32'(bus.clk_active), 32'd0);
      end
      check("gate_off_3", 32'(gate_off_count), 32'd3);
`endif

      // Random requests and force_on against the model.
      phase = "random";
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            bus.req = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         end
         if ($urandom_range(0, 24) == 0) bus.force_on = ~bus.force_on;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dhcen_gate_ctrl.md
Name: dhcen_gate_ctrl

Overview:
Sequences the CE input of a DHCEN clock-gate primitive so that a gated clock domain runs only while a requester needs it. Up to N_REQ requesters assert level requests. The block wakes the clock, waits a settle time, then acknowledges. After a programmable idle period it drains and gates the clock off again. It sits in the always-on clock domain (the DHCEN input clock) next to the DHCEN instance feeding the camera/LCD/SDRAM subdomains.

Parameters:
N_REQ, 2, number of requesters (1..8)
WAKE_CYCLES, 4, clk cycles between enabling DHCEN and first ack (>=1)
IDLE_CYCLES, 8, consecutive request-free cycles in ON before draining (>=1)
GUARD_CYCLES, 2, cycles spent in DRAIN with clock still running before gating off (>=1)
CE_ACTIVE_LOW, 1, 1: dhcen_ce=0 enables the clock; 0: dhcen_ce=1 enables

Ports:
clk  input  1  free-running clock, same net as DHCEN clkin
reset_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester level request for the gated clock
force_on  input  1  holds clock enabled and blocks idle drain
ack  output  N_REQ  per-requester grant: gated clock valid and stable
dhcen_ce  output  1  drives DHCEN CE, polarity per CE_ACTIVE_LOW
clk_active  output  1  1 while the DHCEN clock is enabled (WAKE/ON/DRAIN)
busy  output  1  1 in WAKE or DRAIN (transitional)

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low. All outputs are registered.
- Reset values: state OFF, ack=0, clk_active=0, busy=0, dhcen_ce=disabled level (1 if CE_ACTIVE_LOW, else 0), all counters 0.
- Reset mid-operation forces OFF and disabled CE immediately (asynchronously). DHCEN gating is glitch-free, so the abrupt gate is permitted.
- States: OFF, WAKE, ON, DRAIN.
- OFF -> WAKE:
  - Taken on the first cycle where |req or force_on is sampled high.
  - CE goes to the enabled level and clk_active=1 in the same edge that enters WAKE.
- WAKE:
  - The wake counter counts WAKE_CYCLES cycles, then the FSM enters ON.
  - Requests arriving or dropping during WAKE do not abort it; ack stays 0.
  - If all requests have dropped by the end of WAKE, ON is still entered and the idle count starts.
- ON:
  - ack[i] registered = req[i]. ack[i] first rises on the edge entering ON, i.e. WAKE_CYCLES+1 edges after req was sampled in OFF.
  - ack[i] falls one cycle after req[i] falls.
- Idle counter:
  - Increments each cycle in ON with req==0 and force_on==0.
  - Cleared by any request or force_on.
  - Reaching IDLE_CYCLES moves the FSM to DRAIN.
- DRAIN:
  - ack=0 and busy=1; the clock is still enabled. GUARD_CYCLES counted, then OFF with CE disabled and clk_active=0.
  - Any req or force_on during DRAIN returns to ON next cycle with no WAKE, since the clock never stopped. ack follows in that same ON-entry edge.
- Simultaneous events: a request arriving in the same cycle the guard expires wins, and the FSM returns to ON.
- force_on: in ON, holds the idle counter at 0. It does not by itself raise any ack.
- Counter widths: $clog2(max(WAKE,IDLE,GUARD)+1). Counters saturate and never wrap.
- No arbitration is needed: the clock is shared, so all requesters are acked concurrently.

Optional Feature:
DHCEN_GATE_STATS_EN
- Defined: adds output gate_off_count (16 bits), incremented on each DRAIN->OFF transition and saturating at 0xFFFF. Also adds output on_cycles (32 bits), incremented every cycle clk_active=1, wrapping modulo 2^32. Both reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
1. Reset release with req=00 -> dhcen_ce=1, clk_active=0, ack=00 held for 20 cycles.
2. req=01 at cycle 0 (defaults) -> dhcen_ce=0 at edge 1, busy=1 edges 1-4, ack=01 at edge 5.
3. req[0] drops at cycle 10 -> ack=00 at edge 11. DRAIN entered after 8 idle cycles, busy=1 for 2 cycles, then dhcen_ce=1 and clk_active=0.
4. req=10 asserted on the second DRAIN cycle -> state returns to ON next edge, ack=10 with no WAKE, and dhcen_ce never toggles.
5. force_on=1, req=00 for 50 cycles -> clock enabled after WAKE, never drains, ack=00. Dropping force_on -> DRAIN after 8 cycles.
6. reset_n pulsed low mid-ON with ack=11 -> dhcen_ce disabled and ack=00 before the next clk edge. With DHCEN_GATE_STATS_EN, gate_off_count counts 3 complete on/off cycles as 3.
